// File: rtl/selector_pkg.sv
// selector_pkg: shared pixel width, pixel type and default colour key
package selector_pkg;
    localparam int COLOR_W = 12;
    typedef logic [COLOR_W-1:0] rgb444_t;
    localparam rgb444_t KEY_BLACK = 12'h000;
endpackage

// File: rtl/selector_color_key_detect.sv
// color_key_detect: flags an overlay pixel as opaque when it differs from the key
module color_key_detect #(
    parameter int                 COLOR_W = selector_pkg::COLOR_W,
    parameter logic [COLOR_W-1:0] KEY     = selector_pkg::KEY_BLACK
) (
    input  logic [COLOR_W-1:0] b,
    output logic               opaque
);
    import selector_pkg::*;
    assign opaque = b != KEY;
endmodule

// File: rtl/selector.sv
// selector: colour-keyed overlay mux with registered pixel, select and enable
module selector #(
    parameter int                 COLOR_W = selector_pkg::COLOR_W,
    parameter logic [COLOR_W-1:0] KEY     = selector_pkg::KEY_BLACK
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [COLOR_W-1:0] a,
    input  logic [COLOR_W-1:0] b,
    input  logic               de,
    output logic               s,
    output logic [COLOR_W-1:0] pix,
    output logic               s_q,
    output logic               de_q
);
    import selector_pkg::*;
    logic               w_opaque;
    logic [COLOR_W-1:0] w_pix;
    logic [COLOR_W-1:0] r_pix;
    logic               r_s;
    logic               r_de;
    color_key_detect #(.COLOR_W(COLOR_W), .KEY(KEY)) u_detect (
        .b      (b),
        .opaque (w_opaque)
    );
    assign s = w_opaque;
    // Blanking forces black outside active video
    always_comb w_pix = !de ? '0 : (w_opaque ? b : a);
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pix <= '0;
            r_s   <= 1'b0;
            r_de  <= 1'b0;
        end else begin
            r_pix <= w_pix;
            r_s   <= w_opaque;
            r_de  <= de;
        end
    end
    assign pix  = r_pix;
    assign s_q  = r_s;
    assign de_q = r_de;
endmodule

// File: tb/tb_selector.sv
// tb_selector: directed checks of combinational select and registered outputs
module tb_selector;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] a = 12'h000;
    logic [11:0] b = 12'h000;
    logic        de = 1'b0;
    logic        s;
    logic [11:0] pix;
    logic        s_q;
    logic        de_q;
    int          total = 0;
    int          bad = 0;

    selector dut (
        .clk  (clk),
        .rst  (rst),
        .a    (a),
        .b    (b),
        .de   (de),
        .s    (s),
        .pix  (pix),
        .s_q  (s_q),
        .de_q (de_q)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // drive at negedge, check s before the edge, then registered outputs after it
    task automatic step(input string tag, input logic r, input logic d,
                        input logic [11:0] av, input logic [11:0] bv,
                        input logic es, input logic [11:0] ep,
                        input logic esq, input logic ede);
        @(negedge clk);
        rst = r; de = d; a = av; b = bv;
        #2;
        chk({tag, ".s_pre"}, {11'b0, s}, {11'b0, es});
        @(posedge clk);
        #1;
        chk({tag, ".s_post"}, {11'b0, s}, {11'b0, es});
        chk({tag, ".pix"}, pix, ep);
        chk({tag, ".s_q"}, {11'b0, s_q}, {11'b0, esq});
        chk({tag, ".de_q"}, {11'b0, de_q}, {11'b0, ede});
    endtask

    initial begin
        a = 12'h000; b = 12'h000;
        #3;
        chk("noclk_s", {11'b0, s}, 12'h000);
        b = 12'hFFF;
        #3;
        chk("noclk_s_opaque", {11'b0, s}, 12'h001);
        step("rst",        1'b1, 1'b1, 12'h0A0, 12'hFFF, 1'b1, 12'h000, 1'b0, 1'b0);
        step("rst_rel",    1'b0, 1'b1, 12'h0A0, 12'hFFF, 1'b1, 12'hFFF, 1'b1, 1'b1);
        step("both_key",   1'b0, 1'b1, 12'h000, 12'h000, 1'b0, 12'h000, 1'b0, 1'b1);
        step("bg_green",   1'b0, 1'b1, 12'h0A0, 12'h000, 1'b0, 12'h0A0, 1'b0, 1'b1);
        step("ov_white",   1'b0, 1'b1, 12'h000, 12'hFFF, 1'b1, 12'hFFF, 1'b1, 1'b1);
        step("back_key",   1'b0, 1'b1, 12'h000, 12'h000, 1'b0, 12'h000, 1'b0, 1'b1);
        step("blank",      1'b0, 1'b0, 12'h123, 12'h456, 1'b1, 12'h000, 1'b1, 1'b0);
        step("blank_key",  1'b0, 1'b0, 12'h123, 12'h000, 1'b0, 12'h000, 1'b0, 1'b0);
        step("lsb_diff",   1'b0, 1'b1, 12'h0A0, 12'h001, 1'b1, 12'h001, 1'b1, 1'b1);
        step("msb_diff",   1'b0, 1'b1, 12'h555, 12'h800, 1'b1, 12'h800, 1'b1, 1'b1);
        step("bg_white",   1'b0, 1'b1, 12'hFFF, 12'h000, 1'b0, 12'hFFF, 1'b0, 1'b1);
        step("ov_mix",     1'b0, 1'b1, 12'hABC, 12'h456, 1'b1, 12'h456, 1'b1, 1'b1);
        step("mid_rst",    1'b1, 1'b1, 12'hABC, 12'h456, 1'b1, 12'h000, 1'b0, 1'b0);
        step("mid_rst_bg", 1'b1, 1'b1, 12'hABC, 12'h000, 1'b0, 12'h000, 1'b0, 1'b0);
        step("after_rst",  1'b0, 1'b1, 12'hABC, 12'h000, 1'b0, 12'hABC, 1'b0, 1'b1);
        step("final_ov",   1'b0, 1'b1, 12'h321, 12'h7E7, 1'b1, 12'h7E7, 1'b1, 1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/selector.md
SELECTOR -- requirements
Module: selector

Interface
REQ-001 Parameter COLOR_W, default 12, meaning width of one RGB444 pixel word.
REQ-002 Parameter KEY, default 12'h000, meaning overlay transparency colour key.
REQ-003 The design SHALL use one clock and a synchronous, active-high reset.
REQ-004 Port clk input 1, rising-edge clock for all registers.
REQ-005 Port rst input 1, synchronous active-high reset.
REQ-006 Port a input COLOR_W, background pixel colour.
REQ-007 Port b input COLOR_W, overlay pixel colour.
REQ-008 Port de input 1, display enable (active video) qualifying a/b.
REQ-009 Port s output 1, combinational select: 1 = overlay b opaque, 0 = background a.
REQ-010 Port pix output COLOR_W, registered selected pixel.
REQ-011 Port s_q output 1, registered copy of s.
REQ-012 Port de_q output 1, registered copy of de, aligned with pix.

Function
REQ-013 s SHALL equal 1 exactly when b != KEY, else 0; it is purely combinational, zero latency, and independent of clk, rst and de.
REQ-014 s SHALL ignore a entirely (a=12'h0A0, b=12'h000 gives s=0).
REQ-015 Each rising clk edge with rst=0, pix SHALL load b if s=1 and de=1, a if s=0 and de=1, and 12'h000 if de=0.
REQ-016 Each rising clk edge with rst=0, s_q SHALL load s and de_q SHALL load de; latency of pix/s_q/de_q is exactly 1 cycle.
REQ-017 Partial-key matches do not count: any single bit of b differing from KEY SHALL give s=1 (b=12'h001 gives s=1).
REQ-018 b=KEY with nonzero a SHALL select a; b=KEY with a=KEY SHALL output KEY.
REQ-019 No internal state beyond the three output registers; pixel throughput one per cycle, no stalls.

Reset
REQ-020 When rst=1 on a rising clk edge, pix SHALL become 12'h000, s_q 0 and de_q 0.
REQ-021 Reset SHALL NOT affect s; s keeps tracking b during and after reset.
REQ-022 Reset asserted mid-frame SHALL take effect on the next edge; the first edge after rst deasserts SHALL load normal selected values.

Structure
REQ-023 A shared package selector_pkg SHALL hold COLOR_W, the rgb444_t typedef (COLOR_W-bit vector) and the default key constant KEY_BLACK = 12'h000.
REQ-024 One sub-module color_key_detect SHALL compute the opaque flag (b != KEY); selector instantiates it and adds the output mux and registers.

Verification
REQ-025 a=12'h000, b=12'h000 -> s=0 within 10 ns, no clock required.
REQ-026 a=12'h0A0, b=12'h000 -> s=0; after one edge with de=1, pix=12'h0A0, s_q=0.
REQ-027 a=12'h000, b=12'hFFF -> s=1; after one edge with de=1, pix=12'hFFF, s_q=1.
REQ-028 Return to a=12'h000, b=12'h000 -> s=0 immediately; pix=12'h000 after one edge.
REQ-029 a=12'h123, b=12'h456, de=0 -> s=1, pix=12'h000, de_q=0 after one edge.
REQ-030 rst=1 for one edge with a=12'h0A0, b=12'hFFF, de=1 -> pix=12'h000, s_q=0, de_q=0 while s=1; next edge with rst=0 -> pix=12'hFFF.
